// File: rtl/hazard_tracker_pkg.sv
// hazard_tracker_pkg: shared slot type, bubble constant and default widths for the hazard tracker
package hazard_tracker_pkg;
   localparam int REG_AW_DEF = 3;
   localparam int CNT_W_DEF  = 16;
   localparam logic [REG_AW_DEF-1:0] R0 = '0;
   typedef struct packed {
      logic                  valid;
      logic [REG_AW_DEF-1:0] src1;
      logic [REG_AW_DEF-1:0] src2;
      logic [REG_AW_DEF-1:0] dest;
      logic                  wr_en;
      logic                  mem_read;
   } slot_t;
   localparam slot_t BUBBLE = '0;
endpackage

// File: rtl/hazard_tracker_if.sv
// hazard_tracker_if: ID-stage request, stall and forwarding-unit signals between pipeline (master) and tracker (slave)
// master drives forwarding_en, id_*, flush, stall_count_clr; slave drives stall, ex_src*, dest_*, reg_write_en_*, stall_count
interface hazard_tracker_if
   import hazard_tracker_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF,
   parameter int CNT_W  = CNT_W_DEF
) ();
   logic              forwarding_en;
   logic              id_valid;
   logic [REG_AW-1:0] id_src1;
   logic [REG_AW-1:0] id_src2;
   logic              id_use_src2;
   logic [REG_AW-1:0] id_dest;
   logic              id_reg_write_en;
   logic              id_mem_read;
   logic              flush;
   logic              stall_count_clr;
   logic              stall;
   logic [REG_AW-1:0] ex_src1;
   logic [REG_AW-1:0] ex_src2;
   logic [REG_AW-1:0] dest_Mem;
   logic [REG_AW-1:0] dest_WB;
   logic              reg_write_en_Mem;
   logic              reg_write_en_WB;
   logic [CNT_W-1:0]  stall_count;
   modport master (
      output forwarding_en, id_valid, id_src1, id_src2, id_use_src2, id_dest,
             id_reg_write_en, id_mem_read, flush, stall_count_clr,
      input  stall, ex_src1, ex_src2, dest_Mem, dest_WB,
             reg_write_en_Mem, reg_write_en_WB, stall_count
   );
   modport slave (
      input  forwarding_en, id_valid, id_src1, id_src2, id_use_src2, id_dest,
             id_reg_write_en, id_mem_read, flush, stall_count_clr,
      output stall, ex_src1, ex_src2, dest_Mem, dest_WB,
             reg_write_en_Mem, reg_write_en_WB, stall_count
   );
endinterface

// File: rtl/hazard_tracker_match.sv
// hazard_match: one operand against one slot's pending write; r0 never matches
// ports: s operand, valid/wr_en/dest of the slot, match result
module hazard_match
   import hazard_tracker_pkg::*;
(
   input  logic [REG_AW_DEF-1:0] s,
   input  logic                  valid,
   input  logic                  wr_en,
   input  logic [REG_AW_DEF-1:0] dest,
   output logic                  match
);
   assign match = valid && wr_en && dest == s && s != R0;
endmodule

// File: rtl/hazard_tracker.sv
// hazard_tracker: tracks EX/MEM/WB destination state, raises stall and counts stall cycles
// ports: clk, rst_n (async active-low), bus (slave side of hazard_tracker_if)
module hazard_tracker
   import hazard_tracker_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input logic             clk,
   input logic             rst_n,
   hazard_tracker_if.slave bus
);
   slot_t             sl [3];
   slot_t             id_slot;
   logic [REG_AW-1:0] src2_eff;
   logic [2:0]        m1;
   logic [2:0]        m2;
   logic              hazard;
   logic [CNT_W-1:0]  cnt;
   logic              unused_fields;
   // an immediate form presents r0 as src2 so it can never match
   assign src2_eff = bus.id_use_src2 ? bus.id_src2 : '0;
   for (genvar i = 0; i < 3; i++) begin : g_match
      hazard_match u_m1 (.s(bus.id_src1), .valid(sl[i].valid), .wr_en(sl[i].wr_en), .dest(sl[i].dest), .match(m1[i]));
      hazard_match u_m2 (.s(src2_eff), .valid(sl[i].valid), .wr_en(sl[i].wr_en), .dest(sl[i].dest), .match(m2[i]));
   end
   // with forwarding only a load in EX cannot be bypassed; without it every pending write blocks
   assign hazard    = bus.forwarding_en ? sl[0].mem_read && (m1[0] || m2[0]) : |(m1 | m2);
   assign bus.stall = bus.id_valid && !bus.flush && hazard;
   always_comb id_slot = '{valid: 1'b1, src1: bus.id_src1, src2: bus.id_src2, dest: bus.id_dest,
                           wr_en: bus.id_reg_write_en && bus.id_dest != '0, mem_read: bus.id_mem_read};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sl  <= '{default: BUBBLE};
         cnt <= '0;
      end else begin
         sl[2] <= sl[1];
         sl[1] <= sl[0];
         sl[0] <= (bus.flush || bus.stall || !bus.id_valid) ? BUBBLE : id_slot;
         cnt   <= bus.stall_count_clr ? '0 : (bus.stall && !(&cnt)) ? cnt + 1'b1 : cnt;
      end
   assign bus.ex_src1          = sl[0].src1;
   assign bus.ex_src2          = sl[0].src2;
   assign bus.dest_Mem         = sl[1].dest;
   assign bus.reg_write_en_Mem = sl[1].valid && sl[1].wr_en;
   assign bus.dest_WB          = sl[2].dest;
   assign bus.reg_write_en_WB  = sl[2].valid && sl[2].wr_en;
   assign bus.stall_count      = cnt;
   assign unused_fields = ^{sl[1].src1, sl[1].src2, sl[1].mem_read, sl[2].src1, sl[2].src2, sl[2].mem_read};
endmodule
